// File: rtl/interrupt_controller_pkg.sv
// rtl/interrupt_controller_pkg.sv - register map, trigger modes and field positions for interrupt_controller
package interrupt_controller_pkg;

    typedef enum logic [3:0] {
        IC_ENABLE    = 4'd0,
        IC_THRESHOLD = 4'd1,
        IC_PRIORITY  = 4'd2,
        IC_TRIGGER   = 4'd3,
        IC_PENDING   = 4'd4,
        IC_CLAIM     = 4'd5,
        IC_COMPLETE  = 4'd6
    } ic_reg_t;

    typedef enum logic [1:0] {
        IC_LEVEL_HIGH = 2'd0,
        IC_LEVEL_LOW  = 2'd1,
        IC_EDGE_RISE  = 2'd2,
        IC_EDGE_FALL  = 2'd3
    } ic_trigger_t;

    localparam int IC_ID_FIELD_LSB = 8;

endpackage

// File: rtl/ic_priority_arbiter.sv
// rtl/ic_priority_arbiter.sv - picks the highest-priority eligible interrupt, lowest id on ties
module ic_priority_arbiter #(
    parameter int NUM_INTERRUPTS = 16,
    parameter int PRIORITY_WIDTH = 3,
    parameter int ID_W           = 4
) (
    input  logic [NUM_INTERRUPTS-1:0]                     eligible,
    input  logic [NUM_INTERRUPTS-1:0][PRIORITY_WIDTH-1:0] priorities,
    output logic                                          valid,
    output logic [ID_W-1:0]                               id
);

    logic [PRIORITY_WIDTH-1:0] best;

    // Ascending scan with a strict compare keeps the lowest id among equals.
    always_comb begin
        valid = 1'b0;
        id    = '0;
        best  = '0;
        for (int i = 0; i < NUM_INTERRUPTS; i++) begin
            if (eligible[i] && (!valid || priorities[i] > best)) begin
                valid = 1'b1;
                id    = ID_W'(i);
                best  = priorities[i];
            end
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// rtl/interrupt_controller.sv - per-core interrupt controller with trigger modes, priorities and claim/complete
module interrupt_controller
    import interrupt_controller_pkg::*;
#(
    parameter int  NUM_INTERRUPTS = 16,
    parameter int  NUM_THREADS    = 4,
    parameter int  PRIORITY_WIDTH = 3,
    localparam int TID_W = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1,
    localparam int ID_W  = (NUM_INTERRUPTS > 1) ? $clog2(NUM_INTERRUPTS) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_INTERRUPTS-1:0] interrupt_req,
    input  logic                      reg_write_en,
    input  logic                      reg_read_en,
    input  logic [TID_W-1:0]          reg_thread_idx,
    input  ic_reg_t                   reg_index,
    input  logic [31:0]               reg_write_val,
    output logic [31:0]               ic_read_val,
    output logic [NUM_THREADS-1:0]    ic_interrupt_pending
);

    localparam logic [7:0]     NUM_IDS  = 8'(NUM_INTERRUPTS);
    localparam logic [TID_W:0] NUM_TIDS = (TID_W + 1)'(NUM_THREADS);

    logic [NUM_INTERRUPTS-1:0]                      req_q, req_q2, edge_latch, pending_q, in_service;
    logic [NUM_INTERRUPTS-1:0]                      edge_det, level_val, is_edge, edge_clr, edge_latch_next;
    logic [NUM_THREADS-1:0][NUM_INTERRUPTS-1:0]     enable, eligible;
    logic [NUM_THREADS-1:0][PRIORITY_WIDTH-1:0]     threshold;
    logic [NUM_INTERRUPTS-1:0][PRIORITY_WIDTH-1:0]  prio;
    ic_trigger_t                                    trig_mode [NUM_INTERRUPTS];
    logic [7:0]                                     prio_sel, trig_sel;
    logic [NUM_THREADS-1:0]                         arb_valid;
    logic [NUM_THREADS-1:0][ID_W-1:0]               arb_id;
    logic [31:0]                                    rd_mux;

    logic [7:0]      ind_id, cpl_id;
    logic [ID_W-1:0] ind_idx, cpl_idx, claim_idx;
    logic            ind_id_ok, cpl_id_ok, thread_ok, wr_trigger, claim_fire;
    logic            write_bits_unused;

    assign ind_id     = reg_write_val[IC_ID_FIELD_LSB +: 8];
    assign cpl_id     = reg_write_val[7:0];
    assign ind_idx    = ind_id[ID_W-1:0];
    assign cpl_idx    = cpl_id[ID_W-1:0];
    assign ind_id_ok  = ind_id < NUM_IDS;
    assign cpl_id_ok  = cpl_id < NUM_IDS;
    assign thread_ok  = {1'b0, reg_thread_idx} < NUM_TIDS;
    assign wr_trigger = reg_write_en && reg_index == IC_TRIGGER && ind_id_ok;
    assign claim_idx  = arb_id[reg_thread_idx];
    assign claim_fire = reg_read_en && reg_index == IC_CLAIM && thread_ok && arb_valid[reg_thread_idx];
    assign write_bits_unused = &{1'b0, reg_write_val};

    // Edges are detected on the registered line so every mode sees the same input latency.
    always_comb begin
        edge_det  = '0;
        level_val = req_q;
        is_edge   = '0;
        for (int i = 0; i < NUM_INTERRUPTS; i++) begin
            case (trig_mode[i])
                IC_LEVEL_LOW: level_val[i] = ~req_q[i];
                IC_EDGE_RISE: begin
                    is_edge[i]  = 1'b1;
                    edge_det[i] = req_q[i] & ~req_q2[i];
                end
                IC_EDGE_FALL: begin
                    is_edge[i]  = 1'b1;
                    edge_det[i] = ~req_q[i] & req_q2[i];
                end
                default: ;
            endcase
        end
    end

    // A fresh edge outranks a same-cycle clear so it is never lost.
    always_comb begin
        edge_clr = '0;
        if (claim_fire) edge_clr[claim_idx] = 1'b1;
        if (wr_trigger) edge_clr[ind_idx]   = 1'b1;
        edge_latch_next = (edge_latch & ~edge_clr) | edge_det;
    end

    always_comb begin
        for (int t = 0; t < NUM_THREADS; t++) begin
            for (int i = 0; i < NUM_INTERRUPTS; i++) begin
                eligible[t][i] = pending_q[i] && enable[t][i] && !in_service[i] && (prio[i] > threshold[t]);
            end
        end
    end

    for (genvar t = 0; t < NUM_THREADS; t++) begin : g_arb
        ic_priority_arbiter #(
            .NUM_INTERRUPTS(NUM_INTERRUPTS),
            .PRIORITY_WIDTH(PRIORITY_WIDTH),
            .ID_W          (ID_W)
        ) u_arb (
            .eligible  (eligible[t]),
            .priorities(prio),
            .valid     (arb_valid[t]),
            .id        (arb_id[t])
        );
    end

    always_comb begin
        rd_mux = 32'hffff_ffff;
        case (reg_index)
            IC_ENABLE: begin
                rd_mux = '0;
                if (thread_ok) rd_mux[NUM_INTERRUPTS-1:0] = enable[reg_thread_idx];
            end
            IC_THRESHOLD: begin
                rd_mux = '0;
                if (thread_ok) rd_mux[PRIORITY_WIDTH-1:0] = threshold[reg_thread_idx];
            end
            IC_PRIORITY: begin
                rd_mux = '0;
                if (prio_sel < NUM_IDS) rd_mux[PRIORITY_WIDTH-1:0] = prio[prio_sel[ID_W-1:0]];
            end
            IC_TRIGGER: begin
                rd_mux = '0;
                if (trig_sel < NUM_IDS) rd_mux[1:0] = trig_mode[trig_sel[ID_W-1:0]];
            end
            IC_PENDING: begin
                rd_mux = '0;
                rd_mux[NUM_INTERRUPTS-1:0] = pending_q;
            end
            IC_CLAIM: begin
                rd_mux = '0;
                if (claim_fire) rd_mux[ID_W:0] = {1'b0, claim_idx} + (ID_W + 1)'(1);
            end
            IC_COMPLETE: rd_mux = '0;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            req_q                <= '0;
            req_q2               <= '0;
            edge_latch           <= '0;
            pending_q            <= '0;
            in_service           <= '0;
            enable               <= '0;
            threshold            <= '0;
            prio                 <= '0;
            prio_sel             <= '0;
            trig_sel             <= '0;
            ic_read_val          <= '0;
            ic_interrupt_pending <= '0;
            for (int i = 0; i < NUM_INTERRUPTS; i++) trig_mode[i] <= IC_LEVEL_HIGH;
        end else begin
            req_q                <= interrupt_req;
            req_q2               <= req_q;
            edge_latch           <= edge_latch_next;
            pending_q            <= (is_edge & edge_latch_next) | (~is_edge & level_val);
            ic_interrupt_pending <= arb_valid;
            if (reg_write_en) begin
                case (reg_index)
                    IC_ENABLE:    if (thread_ok) enable[reg_thread_idx] <= reg_write_val[NUM_INTERRUPTS-1:0];
                    IC_THRESHOLD: if (thread_ok) threshold[reg_thread_idx] <= reg_write_val[PRIORITY_WIDTH-1:0];
                    IC_PRIORITY: begin
                        prio_sel <= ind_id;
                        if (ind_id_ok) prio[ind_idx] <= reg_write_val[PRIORITY_WIDTH-1:0];
                    end
                    IC_TRIGGER: begin
                        trig_sel <= ind_id;
                        if (ind_id_ok) trig_mode[ind_idx] <= ic_trigger_t'(reg_write_val[1:0]);
                    end
                    IC_COMPLETE:  if (cpl_id_ok) in_service[cpl_idx] <= 1'b0;
                    default: ;
                endcase
            end
            if (claim_fire) in_service[claim_idx] <= 1'b1;
            if (reg_read_en) ic_read_val <= rd_mux;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) assert (!(reg_read_en && reg_write_en));
    end

endmodule

// File: tb/tb_interrupt_controller.sv
// tb/tb_interrupt_controller.sv - directed and randomized self-checking bench for interrupt_controller
module tb_interrupt_controller;
    import interrupt_controller_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] interrupt_req = '0;
    logic        reg_write_en = 1'b0;
    logic        reg_read_en = 1'b0;
    logic [1:0]  reg_thread_idx = '0;
    ic_reg_t     reg_index = IC_ENABLE;
    logic [31:0] reg_write_val = '0;
    logic [31:0] ic_read_val;
    logic [3:0]  ic_interrupt_pending;

    int checks = 0;
    int errors = 0;

    // Reference state: what software has programmed and what the lines have done.
    int        m_prio [16];
    int        m_mode [16];
    bit [15:0] m_en   [4];
    int        m_thr  [4];
    bit [15:0] m_latch, m_insvc, m_line;

    interrupt_controller #(
        .NUM_INTERRUPTS(16),
        .NUM_THREADS   (4),
        .PRIORITY_WIDTH(3)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .interrupt_req       (interrupt_req),
        .reg_write_en        (reg_write_en),
        .reg_read_en         (reg_read_en),
        .reg_thread_idx      (reg_thread_idx),
        .reg_index           (reg_index),
        .reg_write_val       (reg_write_val),
        .ic_read_val         (ic_read_val),
        .ic_interrupt_pending(ic_interrupt_pending)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input ic_reg_t idx, input int tid, input logic [31:0] val);
        reg_index      = idx;
        reg_thread_idx = 2'(tid);
        reg_write_val  = val;
        reg_write_en   = 1'b1;
        cyc();
        reg_write_en   = 1'b0;
    endtask

    task automatic rd_check(input string tag, input ic_reg_t idx, input int tid, input logic [31:0] exp);
        reg_index      = idx;
        reg_thread_idx = 2'(tid);
        reg_read_en    = 1'b1;
        cyc();
        reg_read_en    = 1'b0;
        check(tag, ic_read_val, exp);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    function automatic bit m_pend(int i);
        case (m_mode[i])
            0:       return m_line[i];
            1:       return !m_line[i];
            default: return m_latch[i];
        endcase
    endfunction

    function automatic bit m_elig(int t, int i);
        return m_pend(i) && m_en[t][i] && !m_insvc[i] && (m_prio[i] > m_thr[t]);
    endfunction

    // Claim answer: find the top priority first, then the first id holding it.
    function automatic int m_best(int t);
        int top = -1;
        for (int i = 0; i < 16; i++) if (m_elig(t, i) && m_prio[i] > top) top = m_prio[i];
        if (top < 0) return 0;
        for (int i = 0; i < 16; i++) if (m_elig(t, i) && m_prio[i] == top) return i + 1;
        return 0;
    endfunction

    function automatic logic [31:0] m_pend_threads();
        logic [31:0] v = '0;
        for (int t = 0; t < 4; t++) v[t] = (m_best(t) != 0);
        return v;
    endfunction

    function automatic logic [31:0] m_pend_vec();
        logic [31:0] v = '0;
        for (int i = 0; i < 16; i++) v[i] = m_pend(i);
        return v;
    endfunction

    initial begin
        logic [15:0] new_line;
        int          t, exp_id, id;

        do_reset();
        check("reset_read_val", ic_read_val, 32'h0);
        check("reset_pending", ic_interrupt_pending, 32'h0);
        rd_check("reset_enable", IC_ENABLE, 0, 32'h0);
        rd_check("reset_threshold", IC_THRESHOLD, 0, 32'h0);
        rd_check("reset_priority", IC_PRIORITY, 0, 32'h0);
        rd_check("reset_trigger", IC_TRIGGER, 0, 32'h0);
        rd_check("reset_pending_reg", IC_PENDING, 0, 32'h0);
        rd_check("reset_claim", IC_CLAIM, 0, 32'h0);
        rd_check("undef_read", ic_reg_t'(4'd9), 0, 32'hffff_ffff);
        wr(IC_ENABLE, 0, 32'h8);
        interrupt_req = 16'h0008;
        repeat (4) cyc();
        check("prio0_not_delivered", ic_interrupt_pending, 32'h0);
        rd_check("prio0_claim", IC_CLAIM, 0, 32'h0);

        // Level-high id 3: latency, claim, complete with line still high
        interrupt_req = '0;
        do_reset();
        wr(IC_PRIORITY, 0, (32'd3 << 8) | 32'd2);
        wr(IC_TRIGGER, 0, (32'd3 << 8) | 32'd0);
        wr(IC_ENABLE, 0, 32'h8);
        rd_check("prio_readback", IC_PRIORITY, 0, 32'd2);
        interrupt_req = 16'h0008;
        cyc();
        cyc();
        check("lat_n2", ic_interrupt_pending, 32'h0);
        cyc();
        check("lat_n3", ic_interrupt_pending, 32'h1);
        rd_check("claim_lvl", IC_CLAIM, 0, 32'd4);
        check("claim_n1_still", ic_interrupt_pending, 32'h1);
        cyc();
        check("claim_n2_drop", ic_interrupt_pending, 32'h0);
        rd_check("pending_unmasked", IC_PENDING, 0, 32'h8);
        wr(IC_COMPLETE, 0, 32'd3);
        cyc();
        check("complete_repend", ic_interrupt_pending, 32'h1);
        wr(IC_PRIORITY, 0, (32'd20 << 8) | 32'd7);
        rd_check("prio_out_of_range", IC_PRIORITY, 0, 32'd0);

        // Rising-edge ids 5 and 9 at equal priority
        interrupt_req = '0;
        do_reset();
        wr(IC_PRIORITY, 0, (32'd5 << 8) | 32'd4);
        wr(IC_PRIORITY, 0, (32'd9 << 8) | 32'd4);
        wr(IC_TRIGGER, 0, (32'd5 << 8) | 32'd2);
        wr(IC_TRIGGER, 0, (32'd9 << 8) | 32'd2);
        wr(IC_ENABLE, 0, 32'h220);
        interrupt_req = 16'h0220;
        cyc();
        interrupt_req = '0;
        repeat (4) cyc();
        check("edge_pending", ic_interrupt_pending, 32'h1);
        rd_check("edge_claim_a", IC_CLAIM, 0, 32'd6);
        rd_check("edge_claim_b", IC_CLAIM, 0, 32'd10);
        rd_check("edge_claim_c", IC_CLAIM, 0, 32'd0);

        // Threshold masking on thread 1
        do_reset();
        wr(IC_PRIORITY, 0, (32'd2 << 8) | 32'd1);
        wr(IC_ENABLE, 1, 32'h4);
        wr(IC_THRESHOLD, 1, 32'd1);
        interrupt_req = 16'h0004;
        repeat (4) cyc();
        check("thresh_block", ic_interrupt_pending, 32'h0);
        wr(IC_THRESHOLD, 1, 32'd0);
        cyc();
        check("thresh_open", ic_interrupt_pending, 32'h2);
        rd_check("enable_readback", IC_ENABLE, 1, 32'h4);

        // Falling-edge id 7: new edge coincides with its claim
        interrupt_req = 16'h0080;
        do_reset();
        wr(IC_PRIORITY, 0, (32'd7 << 8) | 32'd5);
        wr(IC_TRIGGER, 0, (32'd7 << 8) | 32'd3);
        wr(IC_ENABLE, 0, 32'h80);
        rd_check("trigger_readback", IC_TRIGGER, 0, 32'd3);
        interrupt_req = '0;
        repeat (4) cyc();
        check("fall_pending", ic_interrupt_pending, 32'h1);
        interrupt_req = 16'h0080;
        repeat (3) cyc();
        interrupt_req = '0;
        cyc();
        rd_check("fall_claim_race", IC_CLAIM, 0, 32'd8);
        wr(IC_COMPLETE, 0, 32'd7);
        rd_check("fall_latch_kept", IC_CLAIM, 0, 32'd8);
        wr(IC_COMPLETE, 0, 32'd7);
        rd_check("fall_latch_cleared", IC_CLAIM, 0, 32'd0);

        // Shared in_service across threads, then reset mid-operation
        interrupt_req = '0;
        do_reset();
        wr(IC_PRIORITY, 0, (32'd4 << 8) | 32'd3);
        wr(IC_ENABLE, 0, 32'h10);
        wr(IC_ENABLE, 1, 32'h10);
        interrupt_req = 16'h0010;
        repeat (4) cyc();
        check("shared_pending", ic_interrupt_pending, 32'h3);
        rd_check("shared_claim_t0", IC_CLAIM, 0, 32'd5);
        rd_check("shared_claim_t1", IC_CLAIM, 1, 32'd0);
        wr(IC_COMPLETE, 1, 32'd4);
        rd_check("shared_release", IC_CLAIM, 1, 32'd5);
        wr(IC_COMPLETE, 0, 32'd4);
        cyc();
        check("pre_reset_pending", ic_interrupt_pending, 32'h3);
        do_reset();
        check("midop_read_val", ic_read_val, 32'h0);
        check("midop_pending", ic_interrupt_pending, 32'h0);
        repeat (3) cyc();
        check("midop_stays_low", ic_interrupt_pending, 32'h0);

        // Randomized rounds against the reference model
        interrupt_req = '0;
        do_reset();
        m_line  = '0;
        m_latch = '0;
        m_insvc = '0;
        for (int r = 0; r < 12; r++) begin
            for (int i = 0; i < 16; i++) begin
                m_prio[i] = int'($urandom_range(7));
                m_mode[i] = int'($urandom_range(3));
                m_latch[i] = 1'b0;
                wr(IC_PRIORITY, 0, (32'(i) << 8) | 32'(m_prio[i]));
                wr(IC_TRIGGER, 0, (32'(i) << 8) | 32'(m_mode[i]));
            end
            for (int k = 0; k < 4; k++) begin
                m_en[k]  = 16'($urandom);
                m_thr[k] = int'($urandom_range(7));
                wr(IC_ENABLE, k, 32'(m_en[k]));
                wr(IC_THRESHOLD, k, 32'(m_thr[k]));
            end
            for (int i = 0; i < 16; i++) wr(IC_COMPLETE, 0, 32'(i));
            m_insvc  = '0;
            new_line = 16'($urandom);
            for (int i = 0; i < 16; i++) begin
                if (m_mode[i] == 2 && !m_line[i] && new_line[i]) m_latch[i] = 1'b1;
                if (m_mode[i] == 3 && m_line[i] && !new_line[i]) m_latch[i] = 1'b1;
            end
            m_line        = new_line;
            interrupt_req = new_line;
            repeat (5) cyc();
            check("rand_pending", ic_interrupt_pending, m_pend_threads());
            rd_check("rand_pending_reg", IC_PENDING, 0, m_pend_vec());
            for (int c = 0; c < 4; c++) begin
                t      = int'($urandom_range(3));
                exp_id = m_best(t);
                rd_check("rand_claim", IC_CLAIM, t, 32'(exp_id));
                if (exp_id != 0) begin
                    m_insvc[exp_id - 1] = 1'b1;
                    if (m_mode[exp_id - 1] >= 2) m_latch[exp_id - 1] = 1'b0;
                end
            end
            id = int'($urandom_range(15));
            wr(IC_COMPLETE, int'($urandom_range(3)), 32'(id));
            m_insvc[id] = 1'b0;
            repeat (3) cyc();
            check("rand_after_complete", ic_interrupt_pending, m_pend_threads());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/interrupt_controller.md
# interrupt_controller

Parametrised per-core interrupt controller that replaces the fixed edge/level mask-and-pending logic inside the control register block. It supports four trigger modes, per-interrupt priority, per-thread enable masks and thresholds, and a claim/complete handshake that holds an interrupt in service until software completes it. It sits beside the control register file. Its register port is driven from dcache_data_stage, and `ic_interrupt_pending` feeds instruction_decode_stage.

## Interface
Parameters:
- NUM_INTERRUPTS, 16: interrupt sources; 1..32.
- NUM_THREADS, `THREADS_PER_CORE`: hardware threads served.
- PRIORITY_WIDTH, 3: priority field width.

Ports:
- clk  in  1  clock; one clock domain.
- reset  in  1  synchronous, active-high.
- interrupt_req  in  NUM_INTERRUPTS  raw interrupt lines.
- reg_write_en  in  1  register write strobe.
- reg_read_en  in  1  register read strobe; never asserted together with reg_write_en.
- reg_thread_idx  in  $clog2(NUM_THREADS)  thread issuing the access.
- reg_index  in  ic_reg_t  register select.
- reg_write_val  in  32  write data.
- ic_read_val  out  32  read data, registered.
- ic_interrupt_pending  out  NUM_THREADS  per-thread "deliverable interrupt exists", registered.

## Operation
Registers, selected by reg_index:
- IC_ENABLE: per thread, read/write. Enable mask in [NUM_INTERRUPTS-1:0].
- IC_THRESHOLD: per thread, read/write. Threshold in [PRIORITY_WIDTH-1:0].
- IC_PRIORITY: global, indirect.
  - Write: [15:8] is the interrupt id, [PRIORITY_WIDTH-1:0] is the priority.
  - Read: returns the priority of the id held in the last IC_PRIORITY write.
- IC_TRIGGER: global, indirect, same id field. Mode in [1:0]:
  - 0 = level-high, 1 = level-low, 2 = rising edge, 3 = falling edge.
  - Any write clears the edge latch of that id.
- IC_PENDING: read-only. Returns the pending bits, not masked.
- IC_CLAIM: read. Returns id+1 of the best eligible interrupt for this thread, or 0 if none.
  - When the result is nonzero, it also sets in_service[id] and clears edge_latch[id].
- IC_COMPLETE: write. [7:0] is the id; clears in_service[id].
  - An id that is not in service, or is out of range, is a no-op.
- Undefined index: a read returns 32'hffffffff; a write is ignored.

Pending:
- Level modes: pending = the active-level sample of the line.
- Edge modes: edge_latch is set on the sampled edge and held until the interrupt is claimed; pending = edge_latch.

Eligibility and arbitration:
- An interrupt is eligible for thread t when it is pending, enable[t] is set, it is not in_service, and its priority > threshold[t].
- Priority 0 is therefore never delivered.
- The best interrupt is the highest priority; ties go to the lowest id.

in_service is global. Any thread may complete an interrupt that another thread claimed.

Indices and writes outside the parameter ranges are ignored.

## Timing
Reset values:
- All registers, latches and in_service: 0.
- Trigger mode level-high, priority 0.
- ic_read_val = 0, ic_interrupt_pending = 0.

Latencies:
- Input path is `interrupt_req` → req_q → pending_q (registered for every mode) → ic_interrupt_pending register.
- A line change in cycle N produces ic_interrupt_pending in cycle N+3.
- A read in cycle N gives ic_read_val valid in cycle N+1. ic_read_val holds its value when no read occurs.
- Register side effects are visible to arbitration in the next cycle. ic_interrupt_pending drops one cycle after that (claim in N → low in N+2).

Boundary conditions:
- A new edge in the same cycle as a claim of that id: the edge wins and the latch stays set.
- Complete of an id whose level line is still active: the interrupt re-pends next cycle.
- Claim with no eligible interrupt: returns 0 with no side effects.
- Simultaneous read and write: assertion failure.
- reset mid-operation: everything returns to reset values in the next cycle.

## Structure
Shared package (defines.sv):
- ic_reg_t enum.
- ic_trigger_t enum: IC_LEVEL_HIGH, IC_LEVEL_LOW, IC_EDGE_RISE, IC_EDGE_FALL.
- IC_ID_FIELD_LSB = 8.

Sub-module ic_priority_arbiter:
- Combinational; inputs are the eligible vector and the priorities; outputs are valid and id.
- Instantiated once per thread.

## Test plan
- After reset, all reads are 0; raise interrupt_req[3] with default priority 0 → ic_interrupt_pending stays 0.
- Id 3 with priority 2, enable[0]=0x8, level-high; raise req[3] in cycle N:
  - pending[0] = 1 at N+3.
  - Claim → 4, and pending[0] drops at N+2 after the claim.
  - Complete 3 while the line is still high → pending re-asserts.
- Ids 5 and 9 rising-edge, both priority 4, both enabled; pulse both → the claims return 6, then 10, then 0.
- Id 2 with priority 1, thread 1 threshold 1 → not delivered; set threshold 0 → pending[1] = 1.
- Id 7 falling-edge; the line falls in the same cycle as a claim of 7 → the latch stays set, and the next claim returns 8.
- Threads 0 and 1 both enable id 4:
  - Thread 0 claims → 5; thread 1 then claims → 0.
  - Thread 1 completes 4 → in service is released.
